// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the instruction-fetch and data
// masters: one access in flight at a time, round-robin on ties, bus timeout.
module mem_port_arbiter #(
  parameter int          TO_W        = 8,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [15:0] ERR_DATA    = 16'h0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] i_addr_i,
  input  logic [15:0] i_data_i,
  input  logic        i_we_i,
  input  logic        i_stb_i,
  output logic [15:0] i_data_o,
  output logic        i_ack_o,
  input  logic [15:0] d_addr_i,
  input  logic [15:0] d_data_i,
  input  logic        d_we_i,
  input  logic        d_stb_i,
  output logic [15:0] d_data_o,
  output logic        d_ack_o,
  output logic [15:0] m_addr_o,
  output logic [15:0] m_data_o,
  output logic        m_we_o,
  output logic        m_stb_o,
  input  logic [15:0] m_data_i,
  input  logic        m_ack_i,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} grant_t;

  localparam logic [TO_W-1:0] TO_LIMIT = (TIMEOUT_CYC == 0) ? TO_W'(0) : TO_W'(TIMEOUT_CYC - 1);

  state_t          state, state_d;
  grant_t          last_grant, last_grant_d, pick;
  logic [TO_W-1:0] count, count_d;
  logic [15:0]     m_addr_d, m_data_d, i_data_d, d_data_d;
  logic            m_we_d, m_stb_d, i_ack_d, d_ack_d, err_d;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state      <= IDLE;
      last_grant <= GNT_D;
      count      <= '0;
      m_addr_o   <= '0;
      m_data_o   <= '0;
      m_we_o     <= 1'b0;
      m_stb_o    <= 1'b0;
      i_data_o   <= '0;
      i_ack_o    <= 1'b0;
      d_data_o   <= '0;
      d_ack_o    <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      count      <= count_d;
      m_addr_o   <= m_addr_d;
      m_data_o   <= m_data_d;
      m_we_o     <= m_we_d;
      m_stb_o    <= m_stb_d;
      i_data_o   <= i_data_d;
      i_ack_o    <= i_ack_d;
      d_data_o   <= d_data_d;
      d_ack_o    <= d_ack_d;
      err_o      <= err_d;
    end
  end

  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    count_d      = count;
    m_addr_d     = m_addr_o;
    m_data_d     = m_data_o;
    m_we_d       = m_we_o;
    m_stb_d      = m_stb_o;
    i_data_d     = i_data_o;
    d_data_d     = d_data_o;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    err_d        = err_o;
    pick         = GNT_I;

    case (state)
      IDLE: begin
        if (i_stb_i || d_stb_i) begin
          // A tie goes to whichever master was not served last.
          if (i_stb_i && d_stb_i)
            pick = (last_grant == GNT_D) ? GNT_I : GNT_D;
          else
            pick = i_stb_i ? GNT_I : GNT_D;
          m_addr_d     = (pick == GNT_I) ? i_addr_i : d_addr_i;
          m_data_d     = (pick == GNT_I) ? i_data_i : d_data_i;
          m_we_d       = (pick == GNT_I) ? i_we_i : d_we_i;
          m_stb_d      = 1'b1;
          last_grant_d = pick;
          count_d      = '0;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (m_ack_i) begin
          m_stb_d = 1'b0;
          m_we_d  = 1'b0;
          if (last_grant == GNT_I) begin
            i_data_d = m_data_i;
            i_ack_d  = 1'b1;
          end else begin
            d_data_d = m_data_i;
            d_ack_d  = 1'b1;
          end
          state_d = RESP;
        end else if (TIMEOUT_CYC != 0) begin
          // A hung access is completed with error data so the master is not stalled forever.
          if (count == TO_LIMIT) begin
            m_stb_d = 1'b0;
            m_we_d  = 1'b0;
            if (last_grant == GNT_I) begin
              i_data_d = ERR_DATA;
              i_ack_d  = 1'b1;
            end else begin
              d_data_d = ERR_DATA;
              d_ack_d  = 1'b1;
            end
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            count_d = count + TO_W'(1);
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: masters and memory are driven at random
// and every output is compared each cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int          TO_CYC  = 4;
  localparam logic [15:0] ERR_VAL = 16'h0000;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [15:0] i_data_o, d_data_o, m_addr_o, m_data_o;
  logic        i_ack_o, d_ack_o, m_we_o, m_stb_o, busy_o, err_o;
  logic [15:0] m_data_i = '0;
  logic        m_ack_i  = 1'b0;

  // Master-side drive state, index 0 = instruction, 1 = data.
  logic [1:0]  mStb = '0;
  logic [1:0]  mWe  = '0;
  logic [15:0] mAddr [2];
  logic [15:0] mData [2];
  bit          mReq [2];
  bit          mInflight [2];
  bit          mLate [2];

  // Transaction model: when the current access was granted, when it completes,
  // and the earliest cycle a new grant may be taken.
  int          stepNum;
  bit          active;
  int          grantStep, ackStep, freeStep, latency;
  bit          timedOut;
  int          winner, lastServed;
  logic [15:0] gAddr, gData, rdata;
  logic        gWe;
  logic [15:0] expData [2];
  bit          expErr;
  int          nextReset;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 sys_clk = ~sys_clk;

  mem_port_arbiter #(
    .TO_W        (8),
    .TIMEOUT_CYC (TO_CYC),
    .ERR_DATA    (ERR_VAL)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .i_addr_i (mAddr[0]),
    .i_data_i (mData[0]),
    .i_we_i   (mWe[0]),
    .i_stb_i  (mStb[0]),
    .i_data_o (i_data_o),
    .i_ack_o  (i_ack_o),
    .d_addr_i (mAddr[1]),
    .d_data_i (mData[1]),
    .d_we_i   (mWe[1]),
    .d_stb_i  (mStb[1]),
    .d_data_o (d_data_o),
    .d_ack_o  (d_ack_o),
    .m_addr_o (m_addr_o),
    .m_data_o (m_data_o),
    .m_we_o   (m_we_o),
    .m_stb_o  (m_stb_o),
    .m_data_i (m_data_i),
    .m_ack_i  (m_ack_i),
    .busy_o   (busy_o),
    .err_o    (err_o)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at step %0d: got %h, expected %h", tag, stepNum, observed, expected);
    end
  endtask

  task automatic checkStep();
    bit inWait, inBusy, ackNow;
    if (active && stepNum == ackStep) begin
      expData[winner] = timedOut ? ERR_VAL : rdata;
      if (timedOut) expErr = 1'b1;
    end
    inWait = active && stepNum >= grantStep && stepNum < ackStep;
    inBusy = active && stepNum >= grantStep && stepNum <= ackStep;
    ackNow = active && stepNum == ackStep;
    checkOutput("m_stb_o", 16'(m_stb_o), 16'(inWait));
    if (inWait) begin
      checkOutput("m_addr_o", m_addr_o, gAddr);
      checkOutput("m_data_o", m_data_o, gData);
      checkOutput("m_we_o", 16'(m_we_o), 16'(gWe));
    end
    checkOutput("i_ack_o", 16'(i_ack_o), 16'(ackNow && winner == 0));
    checkOutput("d_ack_o", 16'(d_ack_o), 16'(ackNow && winner == 1));
    checkOutput("i_data_o", i_data_o, expData[0]);
    checkOutput("d_data_o", d_data_o, expData[1]);
    checkOutput("busy_o", 16'(busy_o), 16'(inBusy));
    checkOutput("err_o", 16'(err_o), 16'(expErr));
  endtask

  task automatic resetModel();
    active     = 1'b0;
    lastServed = 1;
    expErr     = 1'b0;
    expData[0] = '0;
    expData[1] = '0;
    freeStep   = stepNum + 1;
    m_ack_i    = 1'b0;
    for (int m = 0; m < 2; m++) begin
      mStb[m]      = 1'b0;
      mReq[m]      = 1'b0;
      mInflight[m] = 1'b0;
      mLate[m]     = 1'b0;
    end
  endtask

  task automatic applyStimulus(input bit forceTie);
    bit dropped;
    // Masters: raise, hold, and release requests.
    for (int m = 0; m < 2; m++) begin
      dropped = 1'b0;
      if (mLate[m]) begin
        mStb[m]  = 1'b0;
        mLate[m] = 1'b0;
        dropped  = 1'b1;
      end
      if (active && winner == m && stepNum == ackStep) begin
        mInflight[m] = 1'b0;
        dropped      = 1'b1;
        if ($urandom_range(0, 1) == 1) mLate[m] = 1'b1;
        else mStb[m] = 1'b0;
      end else if (mInflight[m] && active && stepNum == grantStep && $urandom_range(0, 7) == 0) begin
        mStb[m]  = 1'b0;
        mAddr[m] = 16'($urandom);
      end
      if (!dropped && !mReq[m] && !mInflight[m] && !mLate[m] &&
          (forceTie || $urandom_range(0, 2) == 0)) begin
        mStb[m]  = 1'b1;
        mReq[m]  = 1'b1;
        mAddr[m] = 16'($urandom);
        mData[m] = 16'($urandom);
        mWe[m]   = 1'($urandom_range(0, 1));
      end
    end
    // Grant rule: a lone requester wins, a tie goes to the one not served last.
    if (!active && stepNum + 1 >= freeStep && (mStb[0] || mStb[1])) begin
      if (mStb[0] && mStb[1]) winner = 1 - lastServed;
      else winner = mStb[0] ? 0 : 1;
      lastServed        = winner;
      active            = 1'b1;
      grantStep         = stepNum + 1;
      latency           = $urandom_range(0, TO_CYC);
      timedOut          = (latency > TO_CYC - 1);
      ackStep           = timedOut ? grantStep + TO_CYC : grantStep + 1 + latency;
      freeStep          = ackStep + 2;
      gAddr             = mAddr[winner];
      gData             = mData[winner];
      gWe               = mWe[winner];
      mReq[winner]      = 1'b0;
      mInflight[winner] = 1'b1;
    end
    // Memory: ack after the chosen latency; stray acks only while not waiting.
    m_data_i = 16'($urandom);
    if (active && !timedOut && stepNum == grantStep + latency) begin
      m_ack_i = 1'b1;
      rdata   = m_data_i;
    end else if (!(active && stepNum >= grantStep && stepNum < ackStep) && $urandom_range(0, 3) == 0) begin
      m_ack_i = 1'b1;
    end else begin
      m_ack_i = 1'b0;
    end
    if (active && stepNum == ackStep) active = 1'b0;
  endtask

  task automatic pulseReset();
    sys_rst = 1'b0;
    #1;
    checkOutput("rst_m_stb_o", 16'(m_stb_o), 16'h0);
    checkOutput("rst_m_addr_o", m_addr_o, 16'h0);
    checkOutput("rst_m_data_o", m_data_o, 16'h0);
    checkOutput("rst_m_we_o", 16'(m_we_o), 16'h0);
    checkOutput("rst_i_data_o", i_data_o, 16'h0);
    checkOutput("rst_d_data_o", d_data_o, 16'h0);
    checkOutput("rst_i_ack_o", 16'(i_ack_o), 16'h0);
    checkOutput("rst_d_ack_o", 16'(d_ack_o), 16'h0);
    checkOutput("rst_busy_o", 16'(busy_o), 16'h0);
    checkOutput("rst_err_o", 16'(err_o), 16'h0);
    #2;
    sys_rst = 1'b1;
  endtask

  initial begin
    mAddr[0] = '0; mAddr[1] = '0;
    mData[0] = '0; mData[1] = '0;
    stepNum   = 0;
    nextReset = 1000;
    resetModel();
    repeat (3) @(posedge sys_clk);
    #1;
    checkStep();
    sys_rst = 1'b1;
    resetModel();
    applyStimulus(1'b1);
    for (int i = 0; i < 3000; i++) begin
      @(posedge sys_clk);
      #1;
      stepNum++;
      checkStep();
      if (stepNum >= nextReset && active && stepNum >= grantStep && stepNum < ackStep) begin
        pulseReset();
        resetModel();
        nextReset += 1000;
        applyStimulus(1'b1);
      end else begin
        applyStimulus(1'b0);
      end
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between the CPU instruction-fetch master and data load/store master.
- Both masters use stb/we/ack handshakes with a 16-bit address and 16-bit data.
- Sits between the CPU top level and the memory; requests are latched and serialised, one outstanding transaction at a time.
- Round-robin arbitration on ties, plus a bus timeout that completes a hung access with an error flag.

Parameters:
- TO_W, 8, width of the timeout counter.
- TIMEOUT_CYC, 255, wait cycles without m_ack_i before forced completion; 0 disables the timeout; must be < 2^TO_W.
- ERR_DATA, 16'h0000, read data returned to the master on a timeout.

Ports:
- sys_clk  in  1  single clock, rising edge.
- sys_rst  in  1  asynchronous reset, active-low (0 = reset).
- i_addr_i  in  16  instruction master address.
- i_data_i  in  16  instruction master write data.
- i_we_i  in  1  instruction master write enable.
- i_stb_i  in  1  instruction master request.
- i_data_o  out  16  read data to instruction master.
- i_ack_o  out  1  completion pulse to instruction master.
- d_addr_i, d_data_i, d_we_i, d_stb_i, d_data_o, d_ack_o: same widths and meaning, data master.
- m_addr_o  out  16  memory address.
- m_data_o  out  16  memory write data.
- m_we_o  out  1  memory write enable.
- m_stb_o  out  1  memory request.
- m_data_i  in  16  memory read data.
- m_ack_i  in  1  memory completion.
- busy_o  out  1  high in any state other than IDLE.
- err_o  out  1  sticky timeout flag, cleared only by reset.

Behaviour:
- Reset (sys_rst=0, async, also mid-transaction):
  - State goes to IDLE.
  - All outputs go to 0: m_*, i/d_data_o, i/d_ack_o, busy_o, err_o.
  - Timeout counter = 0; last_grant = DATA.
  - An in-flight memory access is abandoned; no ack is issued.
- State IDLE:
  - Sample i_stb_i/d_stb_i.
  - Only one requesting: grant it.
  - Both requesting: grant the master that is not last_grant. After reset the first tie therefore goes to INSTR.
  - On grant, latch the winner's addr/data/we into m_addr_o/m_data_o/m_we_o, set m_stb_o=1, update last_grant, clear the counter, go to WAIT.
  - Neither requesting: stay in IDLE.
- State WAIT:
  - m_stb_o and the latched m_* stay constant.
  - Master inputs are ignored, so address changes after grant have no effect.
  - m_ack_i=1: m_stb_o←0, m_we_o←0; granted master's data_o←m_data_i (also on writes); its ack_o←1; go to RESP.
  - Otherwise, if TIMEOUT_CYC≠0, the counter increments. When counter == TIMEOUT_CYC−1 and m_ack_i=0: m_stb_o←0; data_o←ERR_DATA; ack_o←1; err_o←1; go to RESP.
  - m_ack_i in the same cycle as the timeout limit: the ack wins (normal completion, err_o unchanged).
- State RESP:
  - ack_o is high for exactly this one cycle.
  - Requests are not sampled, so a stb still held in the ack cycle is never re-serviced.
  - Next state: IDLE; ack_o←0.
  - data_o holds its value until that master's next completion.
- m_ack_i is ignored outside WAIT.
- Ungranted master: ack_o stays 0 and it waits with stb held.
- Latency with zero-wait memory (m_ack_i in the first WAIT cycle):
  - stb sampled at cycle 0, m_stb_o at cycle 1, ack_o at cycle 2.
  - Minimum back-to-back spacing is 3 cycles per transaction.
- Masters must hold stb and address stable until their ack_o; a dropped stb after grant does not cancel the access.
- Outputs are registered: no combinational path from any input to any output.
- Fairness: under continuous dual requests the grants alternate I, D, I, D…

Test Plan:
- Reset then a single fetch: i_addr_i=16'h0010, i_stb_i=1, memory acks 2 cycles after m_stb_o with 16'hA55A -> m_addr_o=16'h0010, m_we_o=0; i_data_o=16'hA55A; i_ack_o is a single-cycle pulse; d_ack_o stays 0.
- Simultaneous requests right after reset, I addr 16'h0001, D write addr 16'h0200 data 16'hBEEF -> I served first; then m_addr_o=16'h0200, m_we_o=1, m_data_o=16'hBEEF; both masters held continuously give the grant order I, D, I, D.
- Memory never acks, TIMEOUT_CYC=4 -> m_stb_o high for 4 cycles then drops; granted master gets ack with data 16'h0000; err_o=1 and stays 1 after further normal transactions.
- m_ack_i asserted on the same cycle the counter hits its limit -> normal completion with m_data_i; err_o stays 0.
- Reset pulse while in WAIT -> all outputs 0 immediately; no ack issued; after release, a new request gets its first grant via the reset tie rule (INSTR).
- Master holds stb through its ack cycle and deasserts afterwards -> exactly one memory transaction (single m_stb_o assertion).
